// File: rtl/alu_pkg.sv
// Shared types for the decode/issue stage: ALU opcodes, RV32I opcodes,
// the issued micro-op record and the output buffer states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_SLT = 4'd2,
    ALU_XOR = 4'd3,
    ALU_AND = 4'd4,
    ALU_OR  = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8,
    ALU_NEQ = 4'd9,
    ALU_BLT = 4'd10,
    ALU_BGE = 4'd11
  } aluop_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    aluop_t      aluop;
    logic [31:0] src0;
    logic [31:0] src1;
    logic [4:0]  rd;
    logic        wen;
    logic        branch;
    logic [31:0] target;
    logic        illegal;
  } dispatch_uop_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/alu_dispatch_decode.sv
// Combinational RV32I decoder: instruction, PC and operands to one micro-op.
// Unsupported encodings yield an all-zero micro-op with only illegal set.
module alu_dispatch_decode
  import alu_pkg::*;
(
  input  logic [31:0]   instr,
  input  logic [31:0]   pc,
  input  logic [31:0]   rs1,
  input  logic [31:0]   rs2,
  output dispatch_uop_t uop
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] imm_b;
  logic [31:0] shamt;
  logic        f7_ok;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign shamt  = {27'b0, instr[24:20]};
  // Only ADD/SUB and SRL/SRA slots may carry the alternate funct7.
  assign f7_ok  = (funct7 == F7_ZERO) ||
                  ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

  aluop_t      aluop;
  logic [31:0] src0;
  logic [31:0] src1;
  logic        writes;
  logic        branch;
  logic        bad;

  always_comb begin
    aluop  = ALU_ADD;
    src0   = rs1;
    src1   = rs2;
    writes = 1'b0;
    branch = 1'b0;
    bad    = 1'b0;
    case (opcode)
      OPC_OP: begin
        writes = 1'b1;
        bad    = !f7_ok;
        case (funct3)
          3'b000:  aluop = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          3'b001:  aluop = ALU_SLL;
          3'b010:  aluop = ALU_SLT;
          3'b011:  bad   = 1'b1;
          3'b100:  aluop = ALU_XOR;
          3'b101:  aluop = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          3'b110:  aluop = ALU_OR;
          default: aluop = ALU_AND;
        endcase
      end
      OPC_OP_IMM: begin
        writes = 1'b1;
        src1   = imm_i;
        case (funct3)
          3'b000:  aluop = ALU_ADD;
          3'b010:  aluop = ALU_SLT;
          3'b011:  bad   = 1'b1;
          3'b100:  aluop = ALU_XOR;
          3'b110:  aluop = ALU_OR;
          3'b111:  aluop = ALU_AND;
          3'b001: begin
            src1  = shamt;
            aluop = ALU_SLL;
            bad   = (funct7 != F7_ZERO);
          end
          default: begin
            src1  = shamt;
            aluop = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            bad   = !f7_ok;
          end
        endcase
      end
      OPC_LUI: begin
        writes = 1'b1;
        src0   = '0;
        src1   = imm_u;
      end
      OPC_AUIPC: begin
        writes = 1'b1;
        src0   = pc;
        src1   = imm_u;
      end
      OPC_BRANCH: begin
        branch = 1'b1;
        case (funct3)
          3'b000:  aluop = ALU_SUB;
          3'b001:  aluop = ALU_NEQ;
          3'b100:  aluop = ALU_BLT;
          3'b101:  aluop = ALU_BGE;
          default: bad   = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    uop         = '0;
    uop.illegal = bad;
    if (!bad) begin
      uop.aluop  = aluop;
      uop.src0   = src0;
      uop.src1   = src1;
      uop.branch = branch;
      uop.rd     = writes ? rd : 5'd0;
      uop.wen    = writes && (rd != 5'd0);
      uop.target = branch ? (pc + imm_b) : 32'd0;
    end
  end

endmodule

// File: rtl/alu_dispatch.sv
// Decode-and-issue stage with valid/ready handshake toward the ALU.
// Define ALU_DISPATCH_SKID_EN for a two-entry skid buffer with registered in_ready.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_aluop,
  output logic [XLEN-1:0] out_src0,
  output logic [XLEN-1:0] out_src1,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_branch,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  dispatch_uop_t dec_uop;
  dispatch_uop_t head_q, head_d;
  buf_state_t    state_q, state_d;
  logic          push;
  logic          pop;

  alu_dispatch_decode u_decode (
    .instr (in_instr),
    .pc    (in_pc),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .uop   (dec_uop)
  );

  assign out_valid = (state_q != BUF_EMPTY);
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && in_ready && !flush;

`ifdef ALU_DISPATCH_SKID_EN
  dispatch_uop_t tail_q, tail_d;
  logic          rdy_q, rdy_d;

  assign in_ready = rdy_q && rstn;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          head_d  = dec_uop;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          head_d = dec_uop;
        end else if (push) begin
          tail_d  = dec_uop;
          state_d = BUF_TWO;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      default: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = BUF_ONE;
        end
      end
    endcase
    if (flush) state_d = BUF_EMPTY;
    rdy_d = (state_d != BUF_TWO);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      rdy_q   <= rdy_d;
    end
  end
`else
  assign in_ready = rstn && (!out_valid || out_ready);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    if (push) begin
      head_d  = dec_uop;
      state_d = BUF_ONE;
    end else if (pop) begin
      state_d = BUF_EMPTY;
    end
    if (flush) state_d = BUF_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
    end
  end
`endif

  assign out_aluop   = head_q.aluop;
  assign out_src0    = head_q.src0;
  assign out_src1    = head_q.src1;
  assign out_rd      = head_q.rd;
  assign out_wen     = head_q.wen;
  assign out_branch  = head_q.branch;
  assign out_target  = head_q.target;
  assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: directed decode cases, buffering,
// flush/reset, and a randomized run against a queue-based reference model.
module tb_alu_dispatch;

  typedef struct packed {
    logic [3:0]  aluop;
    logic [31:0] src0;
    logic [31:0] src1;
    logic [4:0]  rd;
    logic        wen;
    logic        branch;
    logic [31:0] target;
    logic        illegal;
  } exp_t;

`ifdef ALU_DISPATCH_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_aluop;
  logic [31:0] out_src0;
  logic [31:0] out_src1;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_branch;
  logic [31:0] out_target;
  logic        out_illegal;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  alu_dispatch #(.XLEN(32)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_aluop   (out_aluop),
    .out_src0    (out_src0),
    .out_src1    (out_src1),
    .out_rd      (out_rd),
    .out_wen     (out_wen),
    .out_branch  (out_branch),
    .out_target  (out_target),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decoder written directly from the RV32I field rules.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int          op;
    int          boff;
    logic [31:0] s0, s1;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    bit          wr, br;
    f7 = ins[31:25];
    f3 = ins[14:12];
    rd = ins[11:7];
    op = -1; s0 = a; s1 = b; wr = 0; br = 0;
    case (ins[6:0])
      7'h33: begin
        wr = 1;
        case ({f7, f3})
          {7'h00, 3'd0}: op = 0;
          {7'h20, 3'd0}: op = 1;
          {7'h00, 3'd1}: op = 6;
          {7'h00, 3'd2}: op = 2;
          {7'h00, 3'd4}: op = 3;
          {7'h00, 3'd5}: op = 7;
          {7'h20, 3'd5}: op = 8;
          {7'h00, 3'd6}: op = 5;
          {7'h00, 3'd7}: op = 4;
          default:       op = -1;
        endcase
      end
      7'h13: begin
        wr = 1;
        s1 = {{20{ins[31]}}, ins[31:20]};
        case (f3)
          3'd0: op = 0;
          3'd2: op = 2;
          3'd4: op = 3;
          3'd6: op = 5;
          3'd7: op = 4;
          3'd1: begin s1 = 32'(ins[24:20]); if (f7 == 7'h00) op = 6; end
          3'd5: begin
            s1 = 32'(ins[24:20]);
            if (f7 == 7'h00) op = 7;
            else if (f7 == 7'h20) op = 8;
          end
          default: op = -1;
        endcase
      end
      7'h37: begin op = 0; wr = 1; s0 = 0; s1 = {ins[31:12], 12'h000}; end
      7'h17: begin op = 0; wr = 1; s0 = pc; s1 = {ins[31:12], 12'h000}; end
      7'h63: begin
        br = 1;
        case (f3)
          3'd0: op = 1;
          3'd1: op = 9;
          3'd4: op = 10;
          3'd5: op = 11;
          default: op = -1;
        endcase
      end
      default: op = -1;
    endcase
    e = '0;
    if (op < 0) begin
      e.illegal = 1'b1;
    end else begin
      e.aluop  = 4'(op);
      e.src0   = s0;
      e.src1   = s1;
      e.branch = br;
      e.rd     = wr ? rd : 5'd0;
      e.wen    = wr && (rd != 5'd0);
      if (br) begin
        boff     = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        e.target = pc + 32'(boff);
      end
    end
    return e;
  endfunction

  function automatic exp_t dut_vec();
    exp_t d;
    d.aluop   = out_aluop;
    d.src0    = out_src0;
    d.src1    = out_src1;
    d.rd      = out_rd;
    d.wen     = out_wen;
    d.branch  = out_branch;
    d.target  = out_target;
    d.illegal = out_illegal;
    return d;
  endfunction

  function automatic bit model_ready();
    if (!rstn) return 1'b0;
    if (CAP == 2) return exp_q.size() < 2;
    return (exp_q.size() == 0) || out_ready;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2: w[6:0] = 7'h33;
      3, 4, 5: w[6:0] = 7'h13;
      6:       w[6:0] = 7'h37;
      7:       w[6:0] = 7'h17;
      8:       w[6:0] = 7'h63;
      default: ;
    endcase
    if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    in_rs1    = a;
    in_rs2    = b;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  // Clock edge plus the model's view of what that edge does to the buffer.
  task automatic advance();
    bit   push, pop;
    exp_t nxt;
    push = model_ready() && in_valid && !flush;
    pop  = (exp_q.size() > 0) && out_ready;
    nxt  = ref_decode(in_instr, in_pc, in_rs1, in_rs2);
    @(posedge clk);
    if (!rstn || flush) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back(nxt);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      advance();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, rand_instr(), $urandom, $urandom, $urandom, 1, 0);
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++;
    if (dut_vec() !== exp_t'('0)) begin errors++; $display("[TB] FAIL reset_fields: got %h want 0", dut_vec()); end
    rstn = 1'b1;
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_decode_directed();
    drive(1, 32'h002081B3, 32'h40, 5, 7, 1, 0);
    advance();
    drive(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_aluop !== 4'd0 || out_src0 !== 32'd5 || out_src1 !== 32'd7 ||
        out_rd !== 5'd3 || out_wen !== 1'b1 || out_illegal !== 1'b0)
    begin errors++; $display("[TB] FAIL add: got v=%b op=%0d s0=%h s1=%h rd=%0d wen=%b want v=1 op=0 s0=5 s1=7 rd=3 wen=1",
                             out_valid, out_aluop, out_src0, out_src1, out_rd, out_wen); end
    advance();

    drive(1, 32'h40335293, 32'h44, 32'h80000000, 0, 1, 0);
    advance();
    drive(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_aluop !== 4'd8 || out_src0 !== 32'h80000000 || out_src1 !== 32'd3 ||
        out_rd !== 5'd5 || out_wen !== 1'b1)
    begin errors++; $display("[TB] FAIL srai: got v=%b op=%0d s0=%h s1=%h rd=%0d wen=%b want v=1 op=8 s0=80000000 s1=3 rd=5 wen=1",
                             out_valid, out_aluop, out_src0, out_src1, out_rd, out_wen); end
    advance();

    drive(1, 32'hFE20CCE3, 32'h100, 11, 22, 1, 0);
    advance();
    drive(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_aluop !== 4'd10 || out_branch !== 1'b1 || out_wen !== 1'b0 ||
        out_target !== 32'hF8 || out_src0 !== 32'd11 || out_src1 !== 32'd22)
    begin errors++; $display("[TB] FAIL blt: got v=%b op=%0d br=%b wen=%b tgt=%h want v=1 op=10 br=1 wen=0 tgt=f8",
                             out_valid, out_aluop, out_branch, out_wen, out_target); end
    advance();

    drive(1, 32'h003130B3, 32'h104, 9, 9, 1, 0);
    advance();
    drive(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_aluop !== 4'd0 || out_wen !== 1'b0)
    begin errors++; $display("[TB] FAIL sltu: got v=%b ill=%b op=%0d wen=%b want v=1 ill=1 op=0 wen=0",
                             out_valid, out_illegal, out_aluop, out_wen); end
    advance();
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    exp_t        e;
    int          acc;
    words[0] = 32'h00500093;
    words[1] = 32'h00A10113;
    words[2] = 32'h40208233;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, words[i], 32'h200 + 32'(4 * i), 32'(100 * i + 1), 32'(3 * i + 2), 0, 0);
      checks++;
      if (in_ready !== model_ready()) begin errors++; $display("[TB] FAIL b2b_in_ready[%0d]: got %b want %b", i, in_ready, model_ready()); end
      if (in_ready === 1'b1) acc++;
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (acc != CAP) begin errors++; $display("[TB] FAIL b2b_accepted: got %0d want %0d", acc, CAP); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full_ready: got %b want 0", in_ready); end
    advance();
    for (int j = 0; j <= CAP; j++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (out_valid !== ((j < CAP) ? 1'b1 : 1'b0)) begin errors++; $display("[TB] FAIL b2b_drain_valid[%0d]: got %b want %b", j, out_valid, j < CAP); end
      if (j < CAP) begin
        e = ref_decode(words[j], 32'h200 + 32'(4 * j), 32'(100 * j + 1), 32'(3 * j + 2));
        checks++;
        if (dut_vec() !== e) begin errors++; $display("[TB] FAIL b2b_drain_order[%0d]: got %h want %h", j, dut_vec(), e); end
      end
      advance();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < CAP; i++) begin
      drive(1, rand_instr(), $urandom, $urandom, $urandom, 0, 0);
      advance();
    end
    drive(1, 32'h00100093, 32'h300, 1, 1, 0, 1);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_prefill: got %b want 1", out_valid); end
    checks++;
    if (in_ready !== model_ready()) begin errors++; $display("[TB] FAIL flush_in_ready: got %b want %b", in_ready, model_ready()); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid: got %b want 0", out_valid); end
    advance();
    drive(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_dropped: got %b want 0", out_valid); end

    for (int i = 0; i < CAP; i++) begin
      drive(1, rand_instr(), $urandom, $urandom, $urandom, 0, 0);
      advance();
    end
    rstn = 1'b0;
    drive(1, 32'h00100093, 32'h300, 1, 1, 0, 0);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready: got %b want 0", in_ready); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || dut_vec() !== exp_t'('0)) begin errors++; $display("[TB] FAIL rst_mid_op: got v=%b f=%h want v=0 f=0", out_valid, dut_vec()); end
    rstn = 1'b1;
    advance();
    drive(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_recover: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom, $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
      checks++;
      if (out_valid !== 1'(exp_q.size() > 0)) begin errors++; $display("[TB] FAIL rand_valid[%0d]: got %b want %b", i, out_valid, exp_q.size() > 0); end
      checks++;
      if (in_ready !== model_ready()) begin errors++; $display("[TB] FAIL rand_in_ready[%0d]: got %b want %b", i, in_ready, model_ready()); end
      if (exp_q.size() > 0) begin
        checks++;
        if (dut_vec() !== exp_q[0]) begin errors++; $display("[TB] FAIL rand_head[%0d]: got %h want %h", i, dut_vec(), exp_q[0]); end
      end
      advance();
    end
  endtask

  initial begin
    rstn      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_decode_directed();
    test_back_to_back();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
